// File: rtl/cache_types.sv
// Shared cache-side types for the L1/L2 memory hierarchy.
//  cache_line  : one full cache line
//  lc3b_word   : one machine word / line address
//  arb_state_t : L2 arbiter FSM state
//  arb_owner_t : which L1 miss path owns the L2 port
package cache_types;

  typedef logic [127:0] cache_line;
  typedef logic [15:0]  lc3b_word;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY,
    ARB_RECOVER
  } arb_state_t;

  typedef enum logic {
    OWNER_I,
    OWNER_D
  } arb_owner_t;

  // The arbiter only ever moves whole lines.
  localparam logic [1:0] ARB_FULL_LINE_BE = 2'b11;

endpackage : cache_types

// File: rtl/l2_arbiter.sv
// l2_arbiter
//  Shares the single unified L2 port between the L1 I-cache and D-cache miss
//  paths. One winning request is captured in IDLE, held stable on the L2 port
//  through BUSY until l2_resp, and the line is handed back to the winner. A
//  single RECOVER cycle follows each transaction so the served L1 can drop its
//  now-stale request before the next arbitration.
//
//  Ports
//   clk, reset_n              clock (rising edge), async active-low reset
//   i_read / i_address        I-cache line read request (level) and address
//   i_rdata / i_resp          line and one-cycle completion pulse to I-cache
//   d_read / d_write          D-cache read / writeback requests (level)
//   d_address / d_wdata       D-cache line address and writeback line
//   d_rdata / d_resp          line and one-cycle completion pulse to D-cache
//   l2_read / l2_write        strobes to L2, held for the whole transaction
//   l2_address / l2_wdata     registered address / write line to L2
//   l2_byte_enable            constant full-line enable
//   l2_rdata / l2_resp        line and completion from L2
//   busy                      a transaction is outstanding
module l2_arbiter
  import cache_types::*;
#(
  parameter int LINE_W     = $bits(cache_line),
  parameter int ADDR_W     = $bits(lc3b_word),
  parameter bit D_PRIORITY = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_address,
  output logic [LINE_W-1:0] l2_wdata,
  output logic [1:0]        l2_byte_enable,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp,
  output logic              busy
);

  arb_state_t state_q, state_d;
  arb_owner_t owner_q, last_grant_q;
  logic       write_q;

  arb_owner_t win;
  logic       win_write;
  logic       req_i, req_d, grant, done;

  // Winner selection and next state.
  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the case can leave one unassigned and infer a latch.
  always_comb begin
    req_i     = i_read;
    req_d     = d_read | d_write;
    win       = req_d ? OWNER_D : OWNER_I;
    grant     = 1'b0;
    state_d   = state_q;

    if (req_i && req_d) begin
      if (D_PRIORITY) win = OWNER_D;
      else            win = (last_grant_q == OWNER_D) ? OWNER_I : OWNER_D;
    end
    // A simultaneous read+write from D issues the writeback first; the read
    // stays asserted and is picked up on a later IDLE cycle.
    win_write = (win == OWNER_D) && d_write;

    case (state_q)
      ARB_IDLE: begin
        if (req_i || req_d) begin
          grant   = 1'b1;
          state_d = ARB_BUSY;
        end
      end
      ARB_BUSY:    if (l2_resp) state_d = ARB_RECOVER;
      ARB_RECOVER: state_d = ARB_IDLE;
      default:     state_d = ARB_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ARB_IDLE;
      owner_q      <= OWNER_D;
      last_grant_q <= OWNER_D;
      write_q      <= 1'b0;
      l2_address   <= '0;
      l2_wdata     <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        owner_q      <= win;
        last_grant_q <= win;
        write_q      <= win_write;
        l2_address   <= (win == OWNER_D) ? d_address : i_address;
        if (win == OWNER_D) l2_wdata <= d_wdata;
      end
    end
  end

  // Strobes decode straight from the state register: they fall the cycle
  // after l2_resp and drop immediately when reset_n is asserted.
  assign busy           = (state_q == ARB_BUSY);
  assign l2_read        = busy && !write_q;
  assign l2_write       = busy && write_q;
  assign l2_byte_enable = ARB_FULL_LINE_BE;

  assign done    = busy && l2_resp;
  assign i_resp  = done && (owner_q == OWNER_I);
  assign d_resp  = done && (owner_q == OWNER_D);
  assign i_rdata = l2_rdata;
  assign d_rdata = l2_rdata;

endmodule : l2_arbiter

// File: tb/tb_l2_arbiter.sv
// Directed bench for l2_arbiter. The bench plays both L1s and the L2. Every
// grant the arbiter is expected to make is pushed onto a scoreboard queue when
// the request is driven; serve() pops it when the L2 strobe appears, checks
// the L2-side view, answers with l2_resp and checks the completion.
// A round-robin instance (dut_rr) and a fixed-priority instance (dut_fp) share
// the stimulus; the one not under test is held in reset.
module tb_l2_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n, fp_reset_n;
  logic         i_read, d_read, d_write, l2_resp;
  logic [15:0]  i_address, d_address;
  logic [127:0] d_wdata, l2_rdata;

  logic [127:0] m_i_rdata, m_d_rdata, m_l2_wdata, f_i_rdata, f_d_rdata, f_l2_wdata;
  logic [15:0]  m_l2_address, f_l2_address;
  logic [1:0]   m_be, f_be;
  logic         m_i_resp, m_d_resp, m_l2_read, m_l2_write, m_busy;
  logic         f_i_resp, f_d_resp, f_l2_read, f_l2_write, f_busy;

  l2_arbiter #(.D_PRIORITY(1'b0)) dut_rr (
    .clk(clk), .reset_n(reset_n),
    .i_read(i_read), .i_address(i_address), .i_rdata(m_i_rdata), .i_resp(m_i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(m_d_rdata), .d_resp(m_d_resp),
    .l2_read(m_l2_read), .l2_write(m_l2_write), .l2_address(m_l2_address),
    .l2_wdata(m_l2_wdata), .l2_byte_enable(m_be), .l2_rdata(l2_rdata),
    .l2_resp(l2_resp), .busy(m_busy)
  );

  l2_arbiter #(.D_PRIORITY(1'b1)) dut_fp (
    .clk(clk), .reset_n(fp_reset_n),
    .i_read(i_read), .i_address(i_address), .i_rdata(f_i_rdata), .i_resp(f_i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(f_d_rdata), .d_resp(f_d_resp),
    .l2_read(f_l2_read), .l2_write(f_l2_write), .l2_address(f_l2_address),
    .l2_wdata(f_l2_wdata), .l2_byte_enable(f_be), .l2_rdata(l2_rdata),
    .l2_resp(l2_resp), .busy(f_busy)
  );

  // Observation mux: the instance under test.
  logic         sel_fp = 1'b0;
  wire          o_l2_read    = sel_fp ? f_l2_read    : m_l2_read;
  wire          o_l2_write   = sel_fp ? f_l2_write   : m_l2_write;
  wire  [15:0]  o_l2_address = sel_fp ? f_l2_address : m_l2_address;
  wire  [127:0] o_l2_wdata   = sel_fp ? f_l2_wdata   : m_l2_wdata;
  wire  [1:0]   o_be         = sel_fp ? f_be         : m_be;
  wire          o_busy       = sel_fp ? f_busy       : m_busy;
  wire          o_i_resp     = sel_fp ? f_i_resp     : m_i_resp;
  wire          o_d_resp     = sel_fp ? f_d_resp     : m_d_resp;
  wire  [127:0] o_i_rdata    = sel_fp ? f_i_rdata    : m_i_rdata;
  wire  [127:0] o_d_rdata    = sel_fp ? f_d_rdata    : m_d_rdata;

  typedef struct {
    logic         owner_d;
    logic         wr;
    logic [15:0]  addr;
    logic [127:0] wdata;
    int           lat;     // negedges from serve() entry to the strobe
  } txn_t;

  txn_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic owner_d, input logic wr, input logic [15:0] addr,
                      input logic [127:0] wdata, input int lat);
    txn_t t;
    t.owner_d = owner_d; t.wr = wr; t.addr = addr; t.wdata = wdata; t.lat = lat;
    exp_q.push_back(t);
  endtask

  // Act as L2 for the next expected transaction. Called on a negedge; returns
  // on the negedge of the RECOVER cycle.
  task automatic serve(input logic [127:0] rdata, input int delay, input bit drop_mid);
    txn_t t;
    int   n = 0;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 1'b1, 1'b0);
      return;
    end
    t = exp_q.pop_front();
    while (!(o_l2_read || o_l2_write) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("grant_latency", n, t.lat);
    if (n >= 20) return;
    check("l2_read",  o_l2_read,  !t.wr);
    check("l2_write", o_l2_write, t.wr);
    check("l2_address", o_l2_address, t.addr);
    if (t.wr) check("l2_wdata", o_l2_wdata, t.wdata);
    check("l2_byte_enable", o_be, 2'b11);
    check("busy", o_busy, 1'b1);
    for (int j = 1; j < delay; j++) begin
      if (drop_mid && j == 1) begin
        i_read = 1'b0;
        d_read = 1'b0;
      end
      @(negedge clk);
      check("hold_strobe", o_l2_read | o_l2_write, 1'b1);
      check("hold_address", o_l2_address, t.addr);
    end
    l2_rdata = rdata;
    l2_resp  = 1'b1;
    #1;
    check("i_resp", o_i_resp, !t.owner_d);
    check("d_resp", o_d_resp, t.owner_d);
    check("rdata", t.owner_d ? o_d_rdata : o_i_rdata, rdata);
    @(negedge clk);
    l2_resp  = 1'b0;
    l2_rdata = '0;
    check("recover_l2_read",  o_l2_read,  1'b0);
    check("recover_l2_write", o_l2_write, 1'b0);
    check("recover_busy",     o_busy,     1'b0);
    check("recover_resp",     o_i_resp | o_d_resp, 1'b0);
  endtask

  localparam logic [127:0] LINE_A = 128'hA0A1_A2A3_A4A5_A6A7_A8A9_AAAB_ACAD_AEAF;
  localparam logic [127:0] LINE_B = 128'hB00B_0000_1111_2222_3333_4444_5555_6666;
  localparam logic [127:0] LINE_W = 128'h5A5A_5A5A_DEAD_BEEF_0123_4567_89AB_CDEF;
  localparam logic [127:0] LINE_W2 = 128'hFEDC_BA98_7654_3210_0F0F_F0F0_1234_5678;

  initial begin
    reset_n = 1'b0; fp_reset_n = 1'b0;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; l2_resp = 1'b0;
    i_address = '0; d_address = '0; d_wdata = '0; l2_rdata = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_l2_read",    m_l2_read,    1'b0);
    check("rst_l2_write",   m_l2_write,   1'b0);
    check("rst_busy",       m_busy,       1'b0);
    check("rst_resp",       m_i_resp | m_d_resp, 1'b0);
    check("rst_l2_address", m_l2_address, 16'h0);
    check("rst_l2_wdata",   m_l2_wdata,   128'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // Lone I read, L2 answers after 4 cycles.
    i_address = 16'h1230; i_read = 1'b1;
    push(1'b0, 1'b0, 16'h1230, '0, 1);
    serve(LINE_A, 4, 1'b0);
    i_read = 1'b0;
    @(negedge clk);

    // D writeback, followed by exactly one RECOVER cycle then IDLE.
    d_address = 16'h4440; d_wdata = LINE_W; d_write = 1'b1;
    push(1'b1, 1'b1, 16'h4440, LINE_W, 1);
    serve(LINE_B, 2, 1'b0);
    d_write = 1'b0;
    @(negedge clk);
    check("idle_after_recover", m_l2_read | m_l2_write, 1'b0);

    // Round-robin contention from reset: I, D, I, D at 3-cycle spacing.
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    i_address = 16'h1000; d_address = 16'h2000;
    i_read = 1'b1; d_read = 1'b1;
    push(1'b0, 1'b0, 16'h1000, '0, 1);
    push(1'b1, 1'b0, 16'h2000, '0, 2);
    push(1'b0, 1'b0, 16'h1000, '0, 2);
    push(1'b1, 1'b0, 16'h2000, '0, 2);
    for (int k = 0; k < 4; k++) serve(LINE_A ^ 128'(k), 1, 1'b0);
    i_read = 1'b0; d_read = 1'b0;
    @(negedge clk);

    // D read and write together: write first, read on a later IDLE.
    d_address = 16'h5550; d_wdata = LINE_W2; d_write = 1'b1; d_read = 1'b1;
    push(1'b1, 1'b1, 16'h5550, LINE_W2, 1);
    push(1'b1, 1'b0, 16'h5550, '0, 2);
    serve(LINE_B, 2, 1'b0);
    d_write = 1'b0;
    serve(LINE_A, 2, 1'b0);
    d_read = 1'b0;
    @(negedge clk);

    // Request dropped mid-transaction still completes; no regrant afterwards.
    d_address = 16'h6660; d_read = 1'b1;
    push(1'b1, 1'b0, 16'h6660, '0, 1);
    serve(LINE_W, 3, 1'b1);
    repeat (2) begin
      @(negedge clk);
      check("no_regrant", m_l2_read | m_l2_write, 1'b0);
    end

    // Reset mid-BUSY drops the strobe at once; the held request is regranted.
    i_address = 16'h7770; i_read = 1'b1;
    @(negedge clk);
    check("pre_reset_strobe", m_l2_read, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_strobe", m_l2_read, 1'b0);
    check("async_reset_busy",   m_busy,    1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    push(1'b0, 1'b0, 16'h7770, '0, 1);
    serve(LINE_B, 2, 1'b0);
    i_read = 1'b0;
    @(negedge clk);

    // Fixed-priority instance: D wins every tie, I only once D lets go.
    reset_n = 1'b0;
    sel_fp  = 1'b1;
    @(negedge clk);
    fp_reset_n = 1'b1;
    i_address = 16'h1111; d_address = 16'h2222;
    i_read = 1'b1; d_read = 1'b1;
    push(1'b1, 1'b0, 16'h2222, '0, 1);
    push(1'b1, 1'b0, 16'h2222, '0, 2);
    serve(LINE_A, 1, 1'b0);
    serve(LINE_B, 2, 1'b0);
    d_read = 1'b0;
    push(1'b0, 1'b0, 16'h1111, '0, 2);
    serve(LINE_W, 1, 1'b0);
    i_read = 1'b0;
    repeat (2) @(negedge clk);
    check("fp_idle", f_l2_read | f_l2_write, 1'b0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_l2_arbiter
